// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants for the programmable tick generator.
//   CLK_HZ   system clock frequency
//   DIV_1HZ  terminal count giving a 1 Hz tick at CLK_HZ (period = D+1)
//   mode_e   channel run mode encoding (periodic / one-shot)
package tick_gen_pkg;

    localparam int CLK_HZ  = 100_000_000;
    localparam int DIV_1HZ = CLK_HZ - 1;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one divider channel of tick_gen.
//   clk, reset     system clock, synchronous active-high reset
//   restart        realign: clears cnt, square and tick
//   wr             decoded config write strobe for this channel
//   wr_div         terminal count D (period D+1 cycles)
//   wr_en          channel enable; writing 1 also clears cnt
//   wr_oneshot     0 periodic, 1 one-shot
//   tick           registered one-cycle pulse at terminal count
//   square         registered toggle on every tick
//   busy           current enable register
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W       = 27,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DIV_1HZ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_en,
    input  logic             wr_oneshot,
    output logic             tick,
    output logic             square,
    output logic             busy
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic             en;
    mode_e            mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            div    <= DEFAULT_DIV;
            en     <= 1'b1;
            mode   <= MODE_PERIODIC;
            tick   <= 1'b0;
            square <= 1'b0;
        end else if (restart) begin
            // config registers are deliberately left alone
            cnt    <= '0;
            square <= 1'b0;
            tick   <= 1'b0;
        end else if (wr) begin
            // a write beats a coinciding terminal count: no tick this cycle
            div  <= wr_div;
            en   <= wr_en;
            mode <= mode_e'(wr_oneshot);
            tick <= 1'b0;
            // restart the period so a smaller D can never leave cnt above div
            if (wr_en)
                cnt <= '0;
        end else if (en) begin
            if (cnt == div) begin
                cnt    <= '0;
                tick   <= 1'b1;
                square <= ~square;
                if (mode == MODE_ONESHOT)
                    en <= 1'b0;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    assign busy = en;

endmodule

// File: rtl/tick_gen.sv
// tick_gen: N_CH independent programmable tick/square generators.
//   clk, reset     system clock, synchronous active-high reset
//   restart        realign every channel (cnt and square to 0)
//   cfg_wr         write strobe for channel cfg_ch
//   cfg_ch         channel index; out-of-range indices are ignored
//   cfg_div        terminal count D, tick period D+1 cycles
//   cfg_en         channel enable
//   cfg_oneshot    0 periodic, 1 one-shot
//   tick           per-channel one-cycle pulse
//   square         per-channel toggle on each tick
//   busy           per-channel enable register
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int               N_CH        = 4,
    parameter int               CNT_W       = 27,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DIV_1HZ),
    localparam int              CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
    input  logic             cfg_oneshot,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  square,
    output logic [N_CH-1:0]  busy
);

    // One-hot write decode; indices >= N_CH match no channel and are dropped.
    logic [N_CH-1:0] wr_sel;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr_sel[i] = cfg_wr && (cfg_ch == CH_W'(i));

        tick_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .restart    (restart),
            .wr         (wr_sel[i]),
            .wr_div     (cfg_div),
            .wr_en      (cfg_en),
            .wr_oneshot (cfg_oneshot),
            .tick       (tick[i]),
            .square     (square[i]),
            .busy       (busy[i])
        );
    end

endmodule
